// File: rtl/mmio_io_hub.sv
// Memory-mapped IO hub: synchronised switches, debounced confirm button with a
// sticky pending flag, LED register and a paired-digit seven-segment scanner.
module mmio_io_hub #(
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FC00,
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned DIGITS          = 8,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic                io_read,
    input  logic                io_write,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [SW_WIDTH-1:0] switch_in,
    input  logic                confirm_in,
    output logic [SW_WIDTH-1:0] led_out,
    output logic [DIGITS-1:0]   tub_sel,
    output logic [7:0]          seg_left,
    output logic [7:0]          seg_right
);
    localparam int unsigned Half  = DIGITS / 2;
    localparam int unsigned KW    = (Half > 1) ? $clog2(Half) : 1;
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SW_WIDTH-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic                btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic                db_level_q, db_level_d, db_prev_q, db_prev_d;
    logic [DbW-1:0]      db_cnt_q, db_cnt_d;
    logic                pending_q, pending_d;
    logic [31:0]         display_q, display_d;
    logic [SW_WIDTH-1:0] led_q, led_d;
    logic                ctrl_q, ctrl_d;
    logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [DIGITS-1:0]   tub_sel_q, tub_sel_d;
    logic [7:0]          seg_left_q, seg_left_d, seg_right_q, seg_right_d;
    logic [3:0]          lo_digit, hi_digit;

    logic       hit;
    logic [2:0] word;
    logic       unused_addr;

    assign hit         = (addr[31:5] == IO_BASE[31:5]);
    assign word        = addr[4:2];
    assign unused_addr = ^addr[1:0];

    // Hex digit to {dp,g,f,e,d,c,b,a}; dp never lit.
    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'h3F;
            4'h1: glyph = 8'h06;
            4'h2: glyph = 8'h5B;
            4'h3: glyph = 8'h4F;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'h6D;
            4'h6: glyph = 8'h7D;
            4'h7: glyph = 8'h07;
            4'h8: glyph = 8'h7F;
            4'h9: glyph = 8'h6F;
            4'hA: glyph = 8'h77;
            4'hB: glyph = 8'h7C;
            4'hC: glyph = 8'h39;
            4'hD: glyph = 8'h5E;
            4'hE: glyph = 8'h79;
            default: glyph = 8'h71;
        endcase
    endfunction

    // Next state: synchronisers, debouncer, pending flag, registers, scanner.
    always_comb begin
        sw_s1_d     = switch_in;
        sw_s2_d     = sw_s1_q;
        btn_s1_d    = confirm_in;
        btn_s2_d    = btn_s1_q;
        db_level_d  = db_level_q;
        db_cnt_d    = '0;
        db_prev_d   = db_level_q;
        pending_d   = pending_q;
        display_d   = display_q;
        led_d       = led_q;
        ctrl_d      = ctrl_q;
        scan_cnt_d  = scan_cnt_q + 1'b1;
        k_d         = k_q;
        tub_sel_d   = '0;
        seg_left_d  = '0;
        seg_right_d = '0;

        // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        if (btn_s2_q != db_level_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        if (io_write && hit) begin
            case (word)
                3'd1: pending_d = 1'b0;
                3'd2: display_d = wdata;
                3'd3: led_d     = wdata[SW_WIDTH-1:0];
                3'd4: ctrl_d    = wdata[0];
                default: ;
            endcase
        end
        // A debounced press beats a simultaneous software clear.
        if (db_level_q && !db_prev_q) begin
            pending_d = 1'b1;
        end

        if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            k_d        = (k_q == KW'(Half - 1)) ? '0 : k_q + 1'b1;
        end

        // Outputs are registered from next-state so they track register writes at once.
        lo_digit = 4'(display_d >> {k_d, 2'b00});
        hi_digit = 4'((display_d >> (4 * Half)) >> {k_d, 2'b00});
        if (ctrl_d) begin
            tub_sel_d   = (DIGITS'(1) << k_d) | ((DIGITS'(1) << Half) << k_d);
            seg_right_d = glyph(lo_digit);
            seg_left_d  = glyph(hi_digit);
        end
    end

    // Combinational read mux into the writeback path.
    always_comb begin
        rdata = '0;
        if (io_read && hit) begin
            case (word)
                3'd0: rdata = 32'(sw_s2_q);
                3'd1: rdata = {31'b0, pending_q};
                3'd2: rdata = display_q;
                3'd3: rdata = 32'(led_q);
                3'd4: rdata = {31'b0, ctrl_q};
                default: rdata = '0;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            db_level_q  <= 1'b0;
            db_prev_q   <= 1'b0;
            db_cnt_q    <= '0;
            pending_q   <= 1'b0;
            display_q   <= '0;
            led_q       <= '0;
            ctrl_q      <= 1'b0;
            scan_cnt_q  <= '0;
            k_q         <= '0;
            tub_sel_q   <= '0;
            seg_left_q  <= '0;
            seg_right_q <= '0;
        end else begin
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            db_level_q  <= db_level_d;
            db_prev_q   <= db_prev_d;
            db_cnt_q    <= db_cnt_d;
            pending_q   <= pending_d;
            display_q   <= display_d;
            led_q       <= led_d;
            ctrl_q      <= ctrl_d;
            scan_cnt_q  <= scan_cnt_d;
            k_q         <= k_d;
            tub_sel_q   <= tub_sel_d;
            seg_left_q  <= seg_left_d;
            seg_right_q <= seg_right_d;
        end
    end

    assign led_out   = led_q;
    assign tub_sel   = tub_sel_q;
    assign seg_left  = seg_left_q;
    assign seg_right = seg_right_q;

endmodule
